// File: rtl/simd_pkg.sv
// simd_pkg: shared definitions for the SIMD integer execution unit.
//   - opcode constants OP_ADD..OP_ANY (10..15 are reserved and yield 0)
//   - state encoding of the EMPTY / MUL / FULL control machine
//   - lane_lsb(): bit position of the least significant bit of a lane
package simd_pkg;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_MUL = 4'd1;
    localparam logic [3:0] OP_SH  = 4'd2;
    localparam logic [3:0] OP_SLT = 4'd3;
    localparam logic [3:0] OP_AND = 4'd4;
    localparam logic [3:0] OP_OR  = 4'd5;
    localparam logic [3:0] OP_XOR = 4'd6;
    localparam logic [3:0] OP_NOT = 4'd7;
    localparam logic [3:0] OP_NEG = 4'd8;
    localparam logic [3:0] OP_ANY = 4'd9;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_MUL   = 2'b01,
        ST_FULL  = 2'b10
    } state_t;

    // Lane i occupies bits [lane_lsb(i, lane_w) +: lane_w] of a word.
    function automatic int unsigned lane_lsb(input int unsigned lane,
                                             input int unsigned lane_w);
        lane_lsb = lane * lane_w;
    endfunction

endpackage

// File: rtl/simd_lane_alu.sv
// simd_lane_alu: combinational single-lane ALU for the arithmetic ops that
// need lane-local behaviour (ADD, SH, SLT, NEG, ANY). Any other opcode gives
// a zero result and zero carry. Instantiated once per lane for packed mode
// and once at full word width for scalar mode.
// Ports:
//   op     in  4   opcode
//   a      in  W   first operand
//   b      in  W   second operand (signed shift amount for SH)
//   res    out W   lane result
//   carry  out 1   carry-out of ADD, 0 otherwise
module simd_lane_alu
    import simd_pkg::*;
#(
    parameter int W = 8
) (
    input  logic [3:0]   op,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] res,
    output logic         carry
);

    // Lane width as a W+1 bit value so a W-bit shift magnitude compares cleanly.
    localparam logic [W:0] LIM = (W+1)'(W);

    logic [W:0]   sum_s;
    logic [W-1:0] mag_s;
    logic [W-1:0] sh_s;

    // Sum with carry, and magnitude of a negative shift amount (the most
    // negative value maps to 2^(W-1), which is still >= W and gives 0).
    always_comb begin
        sum_s = {1'b0, a} + {1'b0, b};
        mag_s = ~b + {{(W-1){1'b0}}, 1'b1};
    end

    // Signed shift: positive = left, negative = logical right, |amt| >= W -> 0.
    always_comb begin
        sh_s = {W{1'b0}};
        if (b[W-1]) begin
            if ({1'b0, mag_s} >= LIM) begin
                sh_s = {W{1'b0}};
            end else begin
                sh_s = a >> mag_s;
            end
        end else begin
            if ({1'b0, b} >= LIM) begin
                sh_s = {W{1'b0}};
            end else begin
                sh_s = a << b;
            end
        end
    end

    // Result and carry selection.
    always_comb begin
        res   = {W{1'b0}};
        carry = 1'b0;
        case (op)
            OP_ADD: begin
                res   = sum_s[W-1:0];
                carry = sum_s[W];
            end
            OP_SH:  res = sh_s;
            OP_SLT: begin
                if ($signed(a) < $signed(b)) begin
                    res = {{(W-1){1'b0}}, 1'b1};
                end else begin
                    res = {W{1'b0}};
                end
            end
            OP_NEG: res = ~a + {{(W-1){1'b0}}, 1'b1};
            OP_ANY: begin
                if (|a) begin
                    res = {W{1'b1}};
                end else begin
                    res = {W{1'b0}};
                end
            end
            default: begin
                res   = {W{1'b0}};
                carry = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/simd_int_exec.sv
// simd_int_exec: SIMD integer execution unit with registered output and
// valid/ready handshakes on both sides. Operates on LANES lanes of LANE_W
// bits (packed) or on the whole WORD_W-bit word (scalar). MUL is an iterative
// shift-add multiplier taking one edge per multiplier bit.
// Ports:
//   clk, reset              clock; asynchronous active-high reset
//   in_valid / in_ready     operation handshake (transfer when both high)
//   in_op, in_packed        opcode; 1 = per lane, 0 = whole word
//   in_a, in_b, in_tag      operands and destination tag
//   out_valid / out_ready   result handshake (drain when both high)
//   out_result, out_tag     registered result and its tag
//   out_carry               per-lane ADD carry (bit 0 in scalar mode)
module simd_int_exec
    import simd_pkg::*;
#(
    parameter  int LANES  = 2,
    parameter  int LANE_W = 8,
    localparam int WORD_W = LANES * LANE_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_op,
    input  logic              in_packed,
    input  logic [WORD_W-1:0] in_a,
    input  logic [WORD_W-1:0] in_b,
    input  logic [3:0]        in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WORD_W-1:0] out_result,
    output logic [3:0]        out_tag,
    output logic [LANES-1:0]  out_carry
);

    localparam int CNT_W = $clog2(WORD_W + 1);
    localparam logic [CNT_W-1:0] K_PACKED = CNT_W'(LANE_W);
    localparam logic [CNT_W-1:0] K_SCALAR = CNT_W'(WORD_W);

    state_t state_r;
    state_t next_state_s;

    logic              accept_s;
    logic              load_alu_s;
    logic              load_mul_s;
    logic              mul_step_s;
    logic              mul_done_s;
    logic              drain_s;

    logic [WORD_W-1:0] pk_res_s;
    logic [LANES-1:0]  pk_carry_s;
    logic [WORD_W-1:0] sc_res_s;
    logic              sc_carry_s;
    logic [WORD_W-1:0] alu_result_s;
    logic [LANES-1:0]  alu_carry_s;

    logic [CNT_W-1:0]  cnt_r;
    logic [WORD_W-1:0] acc_r;
    logic [WORD_W-1:0] mcand_r;
    logic [WORD_W-1:0] mplier_r;
    logic              mul_packed_r;
    logic [3:0]        mul_tag_r;

    logic [WORD_W-1:0] pk_add_s;
    logic [WORD_W-1:0] pk_acc_next_s;
    logic [WORD_W-1:0] pk_mcand_next_s;
    logic [WORD_W-1:0] pk_mplier_next_s;
    logic [WORD_W-1:0] sc_acc_next_s;
    logic [WORD_W-1:0] sc_mcand_next_s;
    logic [WORD_W-1:0] sc_mplier_next_s;
    logic [WORD_W-1:0] acc_next_s;
    logic [WORD_W-1:0] mcand_next_s;
    logic [WORD_W-1:0] mplier_next_s;

    logic              out_valid_r;
    logic [WORD_W-1:0] out_result_r;
    logic [3:0]        out_tag_r;
    logic [LANES-1:0]  out_carry_r;

    // Never ready while multiplying; ready in FULL only if the result drains.
    assign in_ready = (state_r == ST_EMPTY) || ((state_r == ST_FULL) && out_ready);
    assign accept_s = in_valid && in_ready;

    assign out_valid  = out_valid_r;
    assign out_result = out_result_r;
    assign out_tag    = out_tag_r;
    assign out_carry  = out_carry_r;

    // ------------------------------------------------------------------
    // Lane ALUs: one per lane for packed mode, one word-wide for scalar.
    // ------------------------------------------------------------------
    for (genvar i = 0; i < LANES; i++) begin : g_lane
        simd_lane_alu #(.W(LANE_W)) u_lane_alu (
            .op    (in_op),
            .a     (in_a[lane_lsb(i, LANE_W) +: LANE_W]),
            .b     (in_b[lane_lsb(i, LANE_W) +: LANE_W]),
            .res   (pk_res_s[lane_lsb(i, LANE_W) +: LANE_W]),
            .carry (pk_carry_s[i])
        );
    end

    simd_lane_alu #(.W(WORD_W)) u_word_alu (
        .op    (in_op),
        .a     (in_a),
        .b     (in_b),
        .res   (sc_res_s),
        .carry (sc_carry_s)
    );

    // Single-cycle result: bitwise ops ignore in_packed; MUL and reserved give 0.
    always_comb begin
        alu_result_s = {WORD_W{1'b0}};
        alu_carry_s  = {LANES{1'b0}};
        case (in_op)
            OP_AND: alu_result_s = in_a & in_b;
            OP_OR:  alu_result_s = in_a | in_b;
            OP_XOR: alu_result_s = in_a ^ in_b;
            OP_NOT: alu_result_s = ~in_a;
            OP_ADD, OP_SH, OP_SLT, OP_NEG, OP_ANY: begin
                if (in_packed) begin
                    alu_result_s = pk_res_s;
                    alu_carry_s  = pk_carry_s;
                end else begin
                    alu_result_s   = sc_res_s;
                    alu_carry_s[0] = sc_carry_s;
                end
            end
            default: begin
                alu_result_s = {WORD_W{1'b0}};
                alu_carry_s  = {LANES{1'b0}};
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Shift-add multiplier step. Multiplicand shifts left and multiplier
    // shifts right inside each lane, so no bits cross lane boundaries.
    // ------------------------------------------------------------------
    for (genvar i = 0; i < LANES; i++) begin : g_mul_lane
        localparam int LSB = lane_lsb(i, LANE_W);
        assign pk_add_s[LSB +: LANE_W] = mplier_r[LSB] ? mcand_r[LSB +: LANE_W]
                                                       : {LANE_W{1'b0}};
        assign pk_acc_next_s[LSB +: LANE_W]    = acc_r[LSB +: LANE_W] + pk_add_s[LSB +: LANE_W];
        assign pk_mcand_next_s[LSB +: LANE_W]  = {mcand_r[LSB +: LANE_W-1], 1'b0};
        assign pk_mplier_next_s[LSB +: LANE_W] = {1'b0, mplier_r[LSB+1 +: LANE_W-1]};
    end

    assign sc_acc_next_s    = acc_r + (mplier_r[0] ? mcand_r : {WORD_W{1'b0}});
    assign sc_mcand_next_s  = {mcand_r[WORD_W-2:0], 1'b0};
    assign sc_mplier_next_s = {1'b0, mplier_r[WORD_W-1:1]};

    // Pick the packed or scalar multiplier step for the operation in flight.
    always_comb begin
        if (mul_packed_r) begin
            acc_next_s    = pk_acc_next_s;
            mcand_next_s  = pk_mcand_next_s;
            mplier_next_s = pk_mplier_next_s;
        end else begin
            acc_next_s    = sc_acc_next_s;
            mcand_next_s  = sc_mcand_next_s;
            mplier_next_s = sc_mplier_next_s;
        end
    end

    // ------------------------------------------------------------------
    // Control state machine.
    // ------------------------------------------------------------------

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_EMPTY;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state and datapath load controls.
    always_comb begin
        next_state_s = state_r;
        load_alu_s   = 1'b0;
        load_mul_s   = 1'b0;
        mul_step_s   = 1'b0;
        mul_done_s   = 1'b0;
        drain_s      = 1'b0;
        case (state_r)
            ST_EMPTY, ST_FULL: begin
                if (accept_s) begin
                    if (in_op == OP_MUL) begin
                        next_state_s = ST_MUL;
                        load_mul_s   = 1'b1;
                    end else begin
                        next_state_s = ST_FULL;
                        load_alu_s   = 1'b1;
                    end
                end else if ((state_r == ST_FULL) && out_ready) begin
                    next_state_s = ST_EMPTY;
                    drain_s      = 1'b1;
                end else begin
                    next_state_s = state_r;
                end
            end
            ST_MUL: begin
                mul_step_s = 1'b1;
                // Counter was loaded with K; the K-th step finishes the product.
                if (cnt_r <= CNT_W'(1)) begin
                    next_state_s = ST_FULL;
                    mul_done_s   = 1'b1;
                end else begin
                    next_state_s = ST_MUL;
                end
            end
            default: begin
                next_state_s = ST_EMPTY;
            end
        endcase
    end

    // Multiplier operand, accumulator and iteration-counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_r        <= {CNT_W{1'b0}};
            acc_r        <= {WORD_W{1'b0}};
            mcand_r      <= {WORD_W{1'b0}};
            mplier_r     <= {WORD_W{1'b0}};
            mul_packed_r <= 1'b0;
            mul_tag_r    <= 4'd0;
        end else if (load_mul_s) begin
            cnt_r        <= in_packed ? K_PACKED : K_SCALAR;
            acc_r        <= {WORD_W{1'b0}};
            mcand_r      <= in_a;
            mplier_r     <= in_b;
            mul_packed_r <= in_packed;
            mul_tag_r    <= in_tag;
        end else if (mul_step_s) begin
            cnt_r        <= cnt_r - CNT_W'(1);
            acc_r        <= acc_next_s;
            mcand_r      <= mcand_next_s;
            mplier_r     <= mplier_next_s;
        end else begin
            cnt_r        <= cnt_r;
            acc_r        <= acc_r;
        end
    end

    // Output register: loads on a single-cycle accept or multiply completion,
    // clears valid on drain, otherwise holds everything stable.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_r  <= 1'b0;
            out_result_r <= {WORD_W{1'b0}};
            out_tag_r    <= 4'd0;
            out_carry_r  <= {LANES{1'b0}};
        end else if (load_alu_s) begin
            out_valid_r  <= 1'b1;
            out_result_r <= alu_result_s;
            out_tag_r    <= in_tag;
            out_carry_r  <= alu_carry_s;
        end else if (mul_done_s) begin
            out_valid_r  <= 1'b1;
            out_result_r <= acc_next_s;
            out_tag_r    <= mul_tag_r;
            out_carry_r  <= {LANES{1'b0}};
        end else if (drain_s || load_mul_s) begin
            out_valid_r  <= 1'b0;
        end else begin
            out_valid_r  <= out_valid_r;
        end
    end

endmodule
